// File: rtl/imm_ext_ctrl_pkg.sv
// Shared encodings and default widths for the immediate-operand sequencer.
package imm_ext_ctrl_pkg;

  localparam int unsigned IMM_W_DEF   = 16;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TAG_W_DEF   = 5;
  localparam int unsigned GAP_MAX_DEF = 8;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_PREFIX = 2'b11
  } mode_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_PREFIX = 1'b1;

endpackage

// File: rtl/imm_ext_mux.sv
// Combinational operand former: extension modes, or prefix completion when a
// prefix is held.
module imm_ext_mux
  import imm_ext_ctrl_pkg::*;
#(
  parameter int unsigned IMM_W  = IMM_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [IMM_W-1:0]  upper,
  input  logic              in_prefix,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    // A completing request ignores its own extension mode.
    if (in_prefix && !mode[1]) begin
      data = DATA_W'({upper, imm});
    end else begin
      case (mode)
        MODE_ZERO:  data = DATA_W'(imm);
        MODE_SIGN:  data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        MODE_UPPER: data = {imm, {(DATA_W-IMM_W){1'b0}}};
        default:    data = '0;
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_ctrl.sv
// Immediate-operand sequencer: request handshake, prefix pairing FSM with
// gap timeout, and a one-entry registered output stage.
module imm_ext_ctrl
  import imm_ext_ctrl_pkg::*;
#(
  parameter int unsigned IMM_W   = IMM_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned GAP_MAX = GAP_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IMM_W-1:0]  req_imm,
  input  logic [1:0]        req_mode,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              prefix_pend,
  output logic              err_pulse
);

  localparam int unsigned GAP_CW = (GAP_MAX > 2) ? $clog2(GAP_MAX) : 1;
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP_MAX - 1);

  state_t              state;
  logic [GAP_CW-1:0]   gap;
  logic [IMM_W-1:0]    upper;
  logic [DATA_W-1:0]   ext_data;
  logic                accept;
  logic                in_prefix;
  logic                is_prefix;
  logic                emit;
  logic                pair_err;
  logic                timeout;

  assign req_ready   = !flush && (!out_valid || out_ready);
  assign accept      = req_valid && req_ready;
  assign in_prefix   = (state == ST_PREFIX);
  assign is_prefix   = (req_mode == MODE_PREFIX);
  assign emit        = accept && !is_prefix;
  // Upper-placement or a second prefix while one is held breaks the pair.
  assign pair_err    = accept && in_prefix && req_mode[1];
  assign timeout     = in_prefix && !accept && (gap == GAP_LAST);
  assign prefix_pend = in_prefix;

  imm_ext_mux #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .mode      (req_mode),
    .imm       (req_imm),
    .upper     (upper),
    .in_prefix (in_prefix),
    .data      (ext_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      err_pulse <= 1'b0;
      state     <= ST_IDLE;
      gap       <= '0;
      upper     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      err_pulse <= 1'b0;
      state     <= ST_IDLE;
      gap       <= '0;
    end else begin
      err_pulse <= pair_err || timeout;

      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= ext_data;
        out_tag   <= req_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (is_prefix) begin
          upper <= req_imm;
          state <= ST_PREFIX;
          gap   <= '0;
        end else begin
          state <= ST_IDLE;
        end
      end else if (in_prefix) begin
        if (timeout) begin
          state <= ST_IDLE;
          gap   <= '0;
        end else begin
          gap <= gap + GAP_CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Directed bench for imm_ext_ctrl; expected operands go into a scoreboard
// queue and a negedge monitor retires them as the DUT hands them over.
module tb_imm_ext_ctrl;
  import imm_ext_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_imm = '0;
  logic [1:0]  req_mode = '0;
  logic [4:0]  req_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        prefix_pend;
  logic        err_pulse;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned err_seen = 0;

  imm_ext_ctrl #(
    .IMM_W   (16),
    .DATA_W  (32),
    .TAG_W   (5),
    .GAP_MAX (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_imm     (req_imm),
    .req_mode    (req_mode),
    .req_tag     (req_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .prefix_pend (prefix_pend),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_op(input logic [31:0] d, input logic [4:0] t);
    sb.push_back('{data: d, tag: t});
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [1:0] m, input logic [15:0] imm,
                       input logic [4:0] tag, output int unsigned cyc);
    req_valid = 1'b1;
    req_mode  = m;
    req_imm   = imm;
    req_tag   = tag;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!req_ready && cyc < 20);
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: req_ready stayed %b after %0d cycles, expected 1", req_ready, cyc);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (err_pulse) err_seen++;
      if (flush) chk("err_during_flush", {31'b0, err_pulse}, 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_operand: got %h tag %h expected none", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          chk("op_data", out_data, e.data);
          chk("op_tag", {27'b0, out_tag}, {27'b0, e.tag});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c, c1, c2, c3, e0;

    #3;
    chk("rst_low_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_low_data", out_data, 32'd0);
    #9 reset_n = 1'b1;
    step(2);
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("idle_data", out_data, 32'd0);
    chk("idle_pend", {31'b0, prefix_pend}, 32'd0);
    chk("idle_err", {31'b0, err_pulse}, 32'd0);

    // extension modes, back to back
    expect_op(32'h0000_8001, 5'd1);
    expect_op(32'hFFFF_8001, 5'd2);
    expect_op(32'h8001_0000, 5'd3);
    issue(2'b00, 16'h8001, 5'd1, c1);
    issue(2'b01, 16'h8001, 5'd2, c2);
    issue(2'b10, 16'h8001, 5'd3, c3);
    chk("throughput", c1 + c2 + c3, 32'd3);

    // prefix pair
    e0 = err_seen;
    issue(2'b11, 16'hDEAD, 5'd0, c);
    chk("pend_after_prefix", {31'b0, prefix_pend}, 32'd1);
    expect_op(32'hDEAD_BEEF, 5'd7);
    issue(2'b01, 16'hBEEF, 5'd7, c);
    chk("pend_after_pair", {31'b0, prefix_pend}, 32'd0);
    step(1);
    chk("pair_no_err", err_seen - e0, 32'd0);

    // backpressure hold, then retire and load on the same edge
    out_ready = 1'b0;
    expect_op(32'h0000_1234, 5'd4);
    issue(2'b00, 16'h1234, 5'd4, c);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_data", out_data, 32'h0000_1234);
    end
    step(1);
    out_ready = 1'b1;
    expect_op(32'h0000_5678, 5'd5);
    issue(2'b00, 16'h5678, 5'd5, c);
    chk("no_bubble_cycles", c, 32'd1);
    chk("no_bubble_valid", {31'b0, out_valid}, 32'd1);
    chk("no_bubble_data", out_data, 32'h0000_5678);

    // prefix broken by upper-placement
    e0 = err_seen;
    issue(2'b11, 16'hAAAA, 5'd0, c);
    expect_op(32'h0001_0000, 5'd6);
    issue(2'b10, 16'h0001, 5'd6, c);
    chk("err_mode10", {31'b0, err_pulse}, 32'd1);
    chk("pend_mode10", {31'b0, prefix_pend}, 32'd0);
    step(1);
    chk("err_one_cycle", {31'b0, err_pulse}, 32'd0);
    chk("err_count_mode10", err_seen - e0, 32'd1);

    // second prefix replaces the first
    e0 = err_seen;
    issue(2'b11, 16'h1111, 5'd0, c);
    issue(2'b11, 16'h2222, 5'd0, c);
    chk("err_reprefix", {31'b0, err_pulse}, 32'd1);
    chk("pend_reprefix", {31'b0, prefix_pend}, 32'd1);
    expect_op(32'h2222_3333, 5'd8);
    issue(2'b00, 16'h3333, 5'd8, c);
    step(1);
    chk("err_count_reprefix", err_seen - e0, 32'd1);

    // gap timeout after 8 idle cycles
    e0 = err_seen;
    issue(2'b11, 16'h5555, 5'd0, c);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("gap_pend", {31'b0, prefix_pend}, 32'd1);
      chk("gap_no_err", {31'b0, err_pulse}, 32'd0);
    end
    @(negedge clk);
    chk("timeout_err", {31'b0, err_pulse}, 32'd1);
    chk("timeout_pend", {31'b0, prefix_pend}, 32'd0);
    @(negedge clk);
    chk("timeout_err_clear", {31'b0, err_pulse}, 32'd0);
    chk("timeout_err_count", err_seen - e0, 32'd1);
    step(1);

    // completion in the timeout cycle wins
    e0 = err_seen;
    issue(2'b11, 16'hCAFE, 5'd0, c);
    step(7);
    expect_op(32'hCAFE_0BAD, 5'd10);
    issue(2'b00, 16'h0BAD, 5'd10, c);
    chk("late_accept_cycles", c, 32'd1);
    step(2);
    chk("late_accept_no_err", err_seen - e0, 32'd0);

    // flush drops a held operand and blocks acceptance
    out_ready = 1'b0;
    issue(2'b00, 16'h0042, 5'd9, c);
    flush = 1'b1;
    req_valid = 1'b1;
    req_mode = 2'b00;
    req_imm = 16'h0099;
    @(negedge clk);
    chk("flush_ready", {31'b0, req_ready}, 32'd0);
    step(1);
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;

    // flush while a prefix is held
    e0 = err_seen;
    issue(2'b11, 16'h1357, 5'd0, c);
    step(2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_pend", {31'b0, prefix_pend}, 32'd0);
    chk("flush_no_err", {31'b0, err_pulse}, 32'd0);
    step(12);
    chk("flush_no_timeout", err_seen - e0, 32'd0);

    // asynchronous reset mid-prefix
    issue(2'b11, 16'h2468, 5'd0, c);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_pend", {31'b0, prefix_pend}, 32'd0);
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_tag", {27'b0, out_tag}, 32'd0);
    chk("arst_err", {31'b0, err_pulse}, 32'd0);
    #3 reset_n = 1'b1;
    step(2);
    chk("post_rst_pend", {31'b0, prefix_pend}, 32'd0);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
